pixel_sequencer: RTL and testbench
==================================

Name: pixel_sequencer

Overview:
Global frame controller for the digital pixel sensor array. Sequences every frame through erase, exposure, ramp conversion and readout. During conversion it broadcasts the shared conversion code to all pixels. During readout it scans rows and bus-width chunks, driving row/chunk selects and DATA_OUT_CLK so that the pixel top can place OUTPUT_BUS_PIXEL_WIDTH pixels per strobe onto DATA_OUT.

Parameters:
WIDTH, 100, pixel columns
HEIGHT, 100, pixel rows
OUTPUT_BUS_PIXEL_WIDTH, 10, pixels per DATA_OUT word; WIDTH must be a multiple of it, otherwise elaboration error
BIT_DEPTH, 10, conversion code width; conversion lasts 2**BIT_DEPTH cycles
ERASE_CYCLES, 5, cycles ERASE is held (>=1)
EXPOSE_CYCLES, 255, cycles EXPOSE is held (>=1)

Ports:
SYSTEM_CLK  in  1  single clock, rising edge
SYSTEM_RESET  in  1  asynchronous, active-low reset
ENABLE  in  1  level; 1 = run frames continuously
ERASE  out  1  pixel erase
EXPOSE  out  1  pixel exposure
CONVERT  out  1  conversion phase active (comparator/latch enable)
CONV_COUNT  out  BIT_DEPTH  broadcast conversion code
READ_EN  out  1  row/chunk select valid
READ_ROW  out  max(1,$clog2(HEIGHT))  row being read
READ_CHUNK  out  max(1,$clog2(WIDTH/OUTPUT_BUS_PIXEL_WIDTH))  chunk within row
DATA_OUT_CLK  out  1  output data strobe
FRAME_DONE  out  1  one-cycle pulse on last strobe of frame
BUSY  out  1  state != IDLE

Behaviour:
- Reset (SYSTEM_RESET=0, asynchronous): state IDLE; every output 0, including all counters. Reset mid-frame aborts the frame immediately; no FRAME_DONE is issued.
- All outputs are registered. Combinational decode from input to output is not allowed.
- States: IDLE, ERASE, EXPOSE, CONVERT, READ.
- IDLE: ENABLE=1 sampled at an edge -> ERASE starting the next cycle.
- ERASE: ERASE=1 for exactly ERASE_CYCLES cycles -> EXPOSE.
- EXPOSE: EXPOSE=1 for exactly EXPOSE_CYCLES cycles -> CONVERT.
- CONVERT: CONVERT=1 for exactly 2**BIT_DEPTH cycles. CONV_COUNT=0 on the first cycle and increments by 1 per cycle, reaching all-ones on the last cycle. CONV_COUNT is 0 in every other state. Then -> READ.
- READ: CHUNKS = WIDTH/OUTPUT_BUS_PIXEL_WIDTH. Scan order is row 0..HEIGHT-1 outer and chunk 0..CHUNKS-1 inner. Each chunk takes 2 cycles:
  - Phase A: READ_EN=1, READ_ROW/READ_CHUNK valid, DATA_OUT_CLK=0.
  - Phase B: same selects, DATA_OUT_CLK=1.
  - Selects are stable across both phases, so the pixel top latches data on the rising edge of DATA_OUT_CLK.
  - READ lasts 2*HEIGHT*CHUNKS cycles.
- FRAME_DONE=1 during phase B of the last chunk of row HEIGHT-1. On the next edge: ENABLE=1 -> ERASE (back-to-back frames, no gap); ENABLE=0 -> IDLE.
- Deasserting ENABLE mid-frame does not abort; the frame completes and then goes to IDLE.
- Outside READ: READ_EN, READ_ROW, READ_CHUNK and DATA_OUT_CLK are 0.
- Exactly one of ERASE/EXPOSE/CONVERT/READ_EN is 1 while BUSY; all are 0 in IDLE.
- Frame length = ERASE_CYCLES + EXPOSE_CYCLES + 2**BIT_DEPTH + 2*HEIGHT*CHUNKS cycles.
- Phase and scan counters wrap only under state control. Terminal-count compares use exact equality, with no off-by-one at 2**BIT_DEPTH-1.

Decomposition:
- pixel_seq_pkg: state enum (IDLE, ERASE, EXPOSE, CONVERT, READ), and a function computing CHUNKS and the select widths.
- Sub-module readout_scanner: row/chunk/phase counter with start and done, emitting READ_EN, READ_ROW, READ_CHUNK, DATA_OUT_CLK and last.
- Top FSM owns a shared phase-duration counter, reused for ERASE, EXPOSE and CONVERT (CONV_COUNT derived from it).

Test Plan:
All tests use WIDTH=4, HEIGHT=2, OUTPUT_BUS_PIXEL_WIDTH=2, BIT_DEPTH=3, ERASE_CYCLES=2, EXPOSE_CYCLES=3 (frame = 2+3+8+8 = 21 cycles).
1. Hold reset low, toggle ENABLE -> all outputs 0, BUSY=0. Release reset with ENABLE=0 for 10 cycles -> stays IDLE.
2. ENABLE=1 for one frame, then 0 -> ERASE 2 cycles, EXPOSE 3, CONVERT 8 with CONV_COUNT 0..7, READ 8 cycles. Scan sequence (row,chunk) = (0,0),(0,1),(1,0),(1,1), each with DATA_OUT_CLK 0 then 1. FRAME_DONE on cycle 21 only; then IDLE.
3. ENABLE held 1 -> ERASE follows FRAME_DONE on the next cycle; 3 frames take exactly 63 cycles; 3 FRAME_DONE pulses, 21 cycles apart.
4. ENABLE dropped during EXPOSE -> frame completes all 21 cycles, FRAME_DONE pulses, then IDLE.
5. Reset asserted asynchronously mid-READ at (1,0) -> outputs 0 immediately without a clock edge, no FRAME_DONE. After release with ENABLE=1, a full fresh 21-cycle frame runs.
6. Every cycle, assert the one-hot check on ERASE/EXPOSE/CONVERT/READ_EN against BUSY, and CONV_COUNT=0 outside CONVERT.

Source files
------------

// File: rtl/pixel_seq_pkg.sv
// Shared types and elaboration helpers for the pixel frame sequencer.
package pixel_seq_pkg;

  typedef enum logic [2:0] {ST_IDLE, ST_ERASE, ST_EXPOSE, ST_CONVERT, ST_READ} state_t;

  function automatic int chunks(int width, int bus_w);
    return width / bus_w;
  endfunction

  // Select width for a 0..n-1 index; never narrower than one bit.
  function automatic int sel_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Shared phase counter must hold ERASE-1, EXPOSE-1 and the full conversion code.
  function automatic int cnt_w(int erase_c, int expose_c, int bit_depth);
    int w = bit_depth;
    if (sel_w(erase_c) > w) w = sel_w(erase_c);
    if (sel_w(expose_c) > w) w = sel_w(expose_c);
    return w;
  endfunction

endpackage

// File: rtl/pixel_sequencer_readout_scanner.sv
// Row/chunk readout scan: two cycles per chunk, strobe high on the second.
module readout_scanner
  import pixel_seq_pkg::*;
#(
  parameter int HEIGHT = 100,
  parameter int CHUNKS = 10,
  parameter int RW     = sel_w(HEIGHT),
  parameter int CHW    = sel_w(CHUNKS)
) (
  input  logic           gclk,
  input  logic           grst_n,
  input  logic           start,
  output logic           read_en,
  output logic [RW-1:0]  row,
  output logic [CHW-1:0] chunk,
  output logic           dclk,
  output logic           last
);

  localparam logic [RW-1:0]  ROW_LAST   = RW'(HEIGHT - 1);
  localparam logic [CHW-1:0] CHUNK_LAST = CHW'(CHUNKS - 1);

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      read_en <= 1'b0;
      row     <= '0;
      chunk   <= '0;
      dclk    <= 1'b0;
      last    <= 1'b0;
    end else if (start) begin
      read_en <= 1'b1;
      row     <= '0;
      chunk   <= '0;
      dclk    <= 1'b0;
      last    <= 1'b0;
    end else if (read_en) begin
      if (!dclk) begin
        dclk <= 1'b1;
        last <= (row == ROW_LAST) && (chunk == CHUNK_LAST);
      end else begin
        dclk <= 1'b0;
        last <= 1'b0;
        if (chunk == CHUNK_LAST) begin
          chunk <= '0;
          if (row == ROW_LAST) begin
            read_en <= 1'b0;
            row     <= '0;
          end else begin
            row <= row + 1'b1;
          end
        end else begin
          chunk <= chunk + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pixel_sequencer.sv
// Global frame controller: erase, expose, ramp conversion, then row/chunk readout.
module pixel_sequencer
  import pixel_seq_pkg::*;
#(
  parameter int WIDTH                  = 100,
  parameter int HEIGHT                 = 100,
  parameter int OUTPUT_BUS_PIXEL_WIDTH = 10,
  parameter int BIT_DEPTH              = 10,
  parameter int ERASE_CYCLES           = 5,
  parameter int EXPOSE_CYCLES          = 255
) (
  input  logic                                                  SYSTEM_CLK,
  input  logic                                                  SYSTEM_RESET,
  input  logic                                                  ENABLE,
  output logic                                                  ERASE,
  output logic                                                  EXPOSE,
  output logic                                                  CONVERT,
  output logic [BIT_DEPTH-1:0]                                  CONV_COUNT,
  output logic                                                  READ_EN,
  output logic [sel_w(HEIGHT)-1:0]                              READ_ROW,
  output logic [sel_w(chunks(WIDTH, OUTPUT_BUS_PIXEL_WIDTH))-1:0] READ_CHUNK,
  output logic                                                  DATA_OUT_CLK,
  output logic                                                  FRAME_DONE,
  output logic                                                  BUSY
);

  localparam int CHUNKS = chunks(WIDTH, OUTPUT_BUS_PIXEL_WIDTH);
  localparam int CW     = cnt_w(ERASE_CYCLES, EXPOSE_CYCLES, BIT_DEPTH);
  localparam logic [CW-1:0] ERASE_LAST  = CW'(ERASE_CYCLES - 1);
  localparam logic [CW-1:0] EXPOSE_LAST = CW'(EXPOSE_CYCLES - 1);
  localparam logic [CW-1:0] CONV_LAST   = CW'((2 ** BIT_DEPTH) - 1);

  if (WIDTH % OUTPUT_BUS_PIXEL_WIDTH != 0) begin : g_bad_width
    $error("WIDTH must be a multiple of OUTPUT_BUS_PIXEL_WIDTH");
  end

  state_t        state;
  logic [CW-1:0] cnt;
  logic          scan_start;
  logic          scan_last;

  // Scanner loads on the same edge that leaves CONVERT, so READ_EN lines up with state.
  assign scan_start = (state == ST_CONVERT) && (cnt == CONV_LAST);
  assign FRAME_DONE = scan_last;

  always_ff @(posedge SYSTEM_CLK or negedge SYSTEM_RESET) begin
    if (!SYSTEM_RESET) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      ERASE      <= 1'b0;
      EXPOSE     <= 1'b0;
      CONVERT    <= 1'b0;
      CONV_COUNT <= '0;
      BUSY       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (ENABLE) begin
          state <= ST_ERASE;
          ERASE <= 1'b1;
          BUSY  <= 1'b1;
          cnt   <= '0;
        end
        ST_ERASE: if (cnt == ERASE_LAST) begin
          state  <= ST_EXPOSE;
          ERASE  <= 1'b0;
          EXPOSE <= 1'b1;
          cnt    <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
        ST_EXPOSE: if (cnt == EXPOSE_LAST) begin
          state      <= ST_CONVERT;
          EXPOSE     <= 1'b0;
          CONVERT    <= 1'b1;
          CONV_COUNT <= '0;
          cnt        <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
        ST_CONVERT: if (cnt == CONV_LAST) begin
          state      <= ST_READ;
          CONVERT    <= 1'b0;
          CONV_COUNT <= '0;
          cnt        <= '0;
        end else begin
          cnt        <= cnt + 1'b1;
          CONV_COUNT <= BIT_DEPTH'(cnt + 1'b1);
        end
        ST_READ: if (scan_last) begin
          if (ENABLE) begin
            state <= ST_ERASE;
            ERASE <= 1'b1;
          end else begin
            state <= ST_IDLE;
            BUSY  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

  readout_scanner #(
    .HEIGHT (HEIGHT),
    .CHUNKS (CHUNKS)
  ) u_scan (
    .gclk    (SYSTEM_CLK),
    .grst_n  (SYSTEM_RESET),
    .start   (scan_start),
    .read_en (READ_EN),
    .row     (READ_ROW),
    .chunk   (READ_CHUNK),
    .dclk    (DATA_OUT_CLK),
    .last    (scan_last)
  );

endmodule

// File: tb/tb_pixel_sequencer.sv
// Directed bench for pixel_sequencer on a 4x2 array, 2-pixel bus, 3-bit ramp.
module tb_pixel_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       erase, expose, convert, read_en, dclk, frame_done, busy;
  logic [2:0] conv_count;
  logic [0:0] read_row, read_chunk;

  int n_chk  = 0;
  int n_fail = 0;

  // {ERASE,EXPOSE,CONVERT,CONV_COUNT[2:0],READ_EN,ROW,CHUNK,DCLK,FRAME_DONE,BUSY}
  logic [11:0] golden [1:21];
  logic [11:0] obs;

  always #5 clk = ~clk;

  pixel_sequencer #(
    .WIDTH(4), .HEIGHT(2), .OUTPUT_BUS_PIXEL_WIDTH(2),
    .BIT_DEPTH(3), .ERASE_CYCLES(2), .EXPOSE_CYCLES(3)
  ) dut (
    .SYSTEM_CLK   (clk),
    .SYSTEM_RESET (rst_n),
    .ENABLE       (enable),
    .ERASE        (erase),
    .EXPOSE       (expose),
    .CONVERT      (convert),
    .CONV_COUNT   (conv_count),
    .READ_EN      (read_en),
    .READ_ROW     (read_row),
    .READ_CHUNK   (read_chunk),
    .DATA_OUT_CLK (dclk),
    .FRAME_DONE   (frame_done),
    .BUSY         (busy)
  );

  assign obs = {erase, expose, convert, conv_count, read_en, read_row, read_chunk,
                dclk, frame_done, busy};

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Runs 21 frame cycles against the table; sample just after each edge.
  task automatic run_frame(input string tag, input int drop_at, output int done_cnt);
    done_cnt = 0;
    for (int k = 1; k <= 21; k++) begin
      @(posedge clk); #1;
      chk($sformatf("%s_c%0d", tag, k), int'(obs), int'(golden[k]));
      if (frame_done) done_cnt++;
      if (k == drop_at) enable = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    chk("onehot", $countones({erase, expose, convert, read_en}), int'(busy));
    if (!convert) chk("cc_zero", int'(conv_count), 0);
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int dn, total;
    golden[1]  = 12'b1_0_0_000_0_0_0_0_0_1;
    golden[2]  = 12'b1_0_0_000_0_0_0_0_0_1;
    golden[3]  = 12'b0_1_0_000_0_0_0_0_0_1;
    golden[4]  = 12'b0_1_0_000_0_0_0_0_0_1;
    golden[5]  = 12'b0_1_0_000_0_0_0_0_0_1;
    golden[6]  = 12'b0_0_1_000_0_0_0_0_0_1;
    golden[7]  = 12'b0_0_1_001_0_0_0_0_0_1;
    golden[8]  = 12'b0_0_1_010_0_0_0_0_0_1;
    golden[9]  = 12'b0_0_1_011_0_0_0_0_0_1;
    golden[10] = 12'b0_0_1_100_0_0_0_0_0_1;
    golden[11] = 12'b0_0_1_101_0_0_0_0_0_1;
    golden[12] = 12'b0_0_1_110_0_0_0_0_0_1;
    golden[13] = 12'b0_0_1_111_0_0_0_0_0_1;
    golden[14] = 12'b0_0_0_000_1_0_0_0_0_1;
    golden[15] = 12'b0_0_0_000_1_0_0_1_0_1;
    golden[16] = 12'b0_0_0_000_1_0_1_0_0_1;
    golden[17] = 12'b0_0_0_000_1_0_1_1_0_1;
    golden[18] = 12'b0_0_0_000_1_1_0_0_0_1;
    golden[19] = 12'b0_0_0_000_1_1_0_1_0_1;
    golden[20] = 12'b0_0_0_000_1_1_1_0_0_1;
    golden[21] = 12'b0_0_0_000_1_1_1_1_1_1;

    // 1: reset held while ENABLE toggles, then idle with ENABLE low
    rst_n  = 1'b0;
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      enable = ~enable;
      chk($sformatf("rst_hold%0d", i), int'(obs), 0);
    end
    enable = 1'b0;
    #3 rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk($sformatf("idle%0d", i), int'(obs), 0);
    end

    // 2: single frame, ENABLE dropped after it is sampled
    enable = 1'b1;
    run_frame("single", 1, dn);
    chk("single_done_cnt", dn, 1);
    @(posedge clk); #1;
    chk("single_after", int'(obs), 0);
    @(posedge clk); #1;
    chk("single_after2", int'(obs), 0);

    // 3: three back-to-back frames with ENABLE held
    enable = 1'b1;
    total  = 0;
    for (int f = 0; f < 3; f++) begin
      run_frame($sformatf("b2b%0d", f), (f == 2) ? 21 : 0, dn);
      total += dn;
    end
    chk("b2b_done_cnt", total, 3);
    @(posedge clk); #1;
    chk("b2b_after", int'(obs), 0);

    // 4: ENABLE dropped mid-EXPOSE; frame still completes
    enable = 1'b1;
    run_frame("drop", 4, dn);
    chk("drop_done_cnt", dn, 1);
    @(posedge clk); #1;
    chk("drop_after", int'(obs), 0);

    // 5: async reset at READ (1,0), then a fresh frame
    enable = 1'b1;
    dn = 0;
    for (int k = 1; k <= 18; k++) begin
      @(posedge clk); #1;
      chk($sformatf("abort_c%0d", k), int'(obs), int'(golden[k]));
    end
    #2 rst_n = 1'b0;
    #1 chk("abort_async", int'(obs), 0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk($sformatf("abort_hold%0d", i), int'(obs), 0);
    end
    #2 rst_n = 1'b1;
    run_frame("fresh", 21, dn);
    chk("fresh_done_cnt", dn, 1);
    @(posedge clk); #1;
    chk("fresh_after", int'(obs), 0);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
